// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku checker.
//   cell_t      : one 4-bit cell value (0 = empty, 1..9 = digit, 10..15 = illegal)
//   grid_t      : full 9x9 grid of cells, [row][col]
//   chk_state_t : checker FSM states
package sudoku_pkg;

  localparam int unsigned GRID_N      = 9;
  localparam int unsigned BOX_N       = 3;
  localparam int unsigned NUM_GROUPS  = 27;
  localparam int unsigned SCAN_CYCLES = 243;

  typedef logic [3:0] cell_t;
  typedef cell_t grid_t [8:0][8:0];

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } chk_state_t;

endpackage

// File: rtl/sudoku_group_index.sv
// Combinational map from a scan position to a grid coordinate.
//   grp_i : group number, 0..8 rows, 9..17 columns, 18..26 boxes
//   idx_i : cell position inside the group, 0..8
//   row_o : grid row of the addressed cell
//   col_o : grid column of the addressed cell
module sudoku_group_index #(
  parameter int unsigned BOX_N = 3
) (
  input  logic [4:0] grp_i,
  input  logic [3:0] idx_i,
  output logic [3:0] row_o,
  output logic [3:0] col_o
);
  import sudoku_pkg::*;

  logic [4:0] box;

  always_comb begin
    box   = '0;
    row_o = '0;
    col_o = '0;
    if (grp_i < 5'(GRID_N)) begin
      row_o = grp_i[3:0];
      col_o = idx_i;
    end else if (grp_i < 5'(2 * GRID_N)) begin
      row_o = idx_i;
      col_o = 4'(grp_i - 5'(GRID_N));
    end else begin
      // Boxes are numbered row-major; cells inside a box are also row-major.
      box   = grp_i - 5'(2 * GRID_N);
      row_o = 4'((box / BOX_N) * BOX_N + idx_i / BOX_N);
      col_o = 4'((box % BOX_N) * BOX_N + idx_i % BOX_N);
    end
  end

endmodule

// File: rtl/sudoku_checker.sv
// Sudoku board checker. Snapshots the 9x9 grid on start, then walks all 27 groups
// (rows, columns, boxes) one cell per clock and reports conflict / filled / solved.
// done pulses exactly 244 cycles after the start cycle; results hold until the next
// accepted start or reset.
//   clock, reset           : system clock, synchronous active-high reset
//   start                  : check request, accepted only in IDLE
//   grid                   : display grid, [row][col]
//   busy, done             : scan in progress / one-cycle completion pulse
//   result_valid           : conflict/filled/solved hold a completed check
//   conflict/filled/solved : check results
//   conf_row/conf_col      : first conflicting cell (only with CONFLICT_LOC_EN)
// Build option: define CONFLICT_LOC_EN to add conflict location capture.
module sudoku_checker #(
  parameter int unsigned GRID_N = 9,
  parameter int unsigned BOX_N  = 3,
  parameter int unsigned VAL_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [VAL_W-1:0] grid [GRID_N-1:0][GRID_N-1:0],
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic             conflict,
  output logic             filled,
  output logic             solved
`ifdef CONFLICT_LOC_EN
  ,
  output logic [3:0]       conf_row,
  output logic [3:0]       conf_col
`endif
);
  import sudoku_pkg::*;

  chk_state_t state_q, state_d;
  logic [4:0] grp_q, grp_d;
  logic [3:0] idx_q, idx_d;
  cell_t      grid_q [8:0][8:0];
  cell_t      grid_d [8:0][8:0];
  logic [8:0] seen_q, seen_d;
  logic       empty_q, empty_d;
  logic       acc_conf_q, acc_conf_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       valid_q, valid_d;
  logic       conflict_q, conflict_d;
  logic       filled_q, filled_d;
  logic       solved_q, solved_d;
`ifdef CONFLICT_LOC_EN
  logic [3:0] loc_row_q, loc_row_d, loc_col_q, loc_col_d;
  logic [3:0] conf_row_q, conf_row_d, conf_col_q, conf_col_d;
`endif

  logic [3:0] cur_row, cur_col;
  cell_t      cur_val;
  logic       hit;

  sudoku_group_index #(
    .BOX_N(BOX_N)
  ) u_group_index (
    .grp_i(grp_q),
    .idx_i(idx_q),
    .row_o(cur_row),
    .col_o(cur_col)
  );

  always_comb begin
    state_d    = state_q;
    grp_d      = grp_q;
    idx_d      = idx_q;
    grid_d     = grid_q;
    seen_d     = seen_q;
    empty_d    = empty_q;
    acc_conf_d = acc_conf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    conflict_d = conflict_q;
    filled_d   = filled_q;
    solved_d   = solved_q;
`ifdef CONFLICT_LOC_EN
    loc_row_d  = loc_row_q;
    loc_col_d  = loc_col_q;
    conf_row_d = conf_row_q;
    conf_col_d = conf_col_q;
`endif
    hit        = 1'b0;
    cur_val    = grid_q[cur_row][cur_col];

    case (state_q)
      IDLE: begin
        if (start) begin
          grid_d     = grid;
          seen_d     = '0;
          empty_d    = 1'b0;
          acc_conf_d = 1'b0;
          grp_d      = '0;
          idx_d      = '0;
          busy_d     = 1'b1;
          valid_d    = 1'b0;
          conflict_d = 1'b0;
          filled_d   = 1'b0;
          solved_d   = 1'b0;
`ifdef CONFLICT_LOC_EN
          loc_row_d  = '0;
          loc_col_d  = '0;
          conf_row_d = '0;
          conf_col_d = '0;
`endif
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (cur_val == 4'd0) begin
          empty_d = 1'b1;
        end else if (cur_val <= 4'd9) begin
          if (seen_q[4'(cur_val - 4'd1)]) hit = 1'b1;
          else seen_d[4'(cur_val - 4'd1)] = 1'b1;
        end else begin
          hit = 1'b1;
        end
        if (hit) acc_conf_d = 1'b1;
`ifdef CONFLICT_LOC_EN
        // Only the first offending cell in scan order is recorded.
        if (hit && !acc_conf_q) begin
          loc_row_d = cur_row;
          loc_col_d = cur_col;
        end
`endif
        if (idx_q == 4'(GRID_N - 1)) begin
          seen_d = '0;
          idx_d  = '0;
          grp_d  = grp_q + 5'd1;
          if (grp_q == 5'(NUM_GROUPS - 1)) begin
            // Results are registered on entry to DONE so they appear with done.
            grp_d      = '0;
            state_d    = DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            valid_d    = 1'b1;
            conflict_d = acc_conf_d;
            filled_d   = !empty_d;
            solved_d   = !empty_d && !acc_conf_d;
`ifdef CONFLICT_LOC_EN
            conf_row_d = acc_conf_d ? loc_row_d : 4'd0;
            conf_col_d = acc_conf_d ? loc_col_d : 4'd0;
`endif
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grp_q      <= '0;
      idx_q      <= '0;
      seen_q     <= '0;
      empty_q    <= 1'b0;
      acc_conf_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      filled_q   <= 1'b0;
      solved_q   <= 1'b0;
`ifdef CONFLICT_LOC_EN
      loc_row_q  <= '0;
      loc_col_q  <= '0;
      conf_row_q <= '0;
      conf_col_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      idx_q      <= idx_d;
      grid_q     <= grid_d;
      seen_q     <= seen_d;
      empty_q    <= empty_d;
      acc_conf_q <= acc_conf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
      filled_q   <= filled_d;
      solved_q   <= solved_d;
`ifdef CONFLICT_LOC_EN
      loc_row_q  <= loc_row_d;
      loc_col_q  <= loc_col_d;
      conf_row_q <= conf_row_d;
      conf_col_q <= conf_col_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_valid = valid_q;
  assign conflict     = conflict_q;
  assign filled       = filled_q;
  assign solved       = solved_q;
`ifdef CONFLICT_LOC_EN
  assign conf_row     = conf_row_q;
  assign conf_col     = conf_col_q;
`endif

endmodule

// File: tb/tb_sudoku_checker.sv
// Scoreboard bench for sudoku_checker: stimulus pushes expected results, the monitor
// pops and compares on every done pulse (including the 244-cycle latency).
module tb_sudoku_checker;
  import sudoku_pkg::*;

  logic  clock = 1'b0;
  logic  reset, start;
  grid_t grid;
  logic  busy, done, result_valid, conflict, filled, solved;
`ifdef CONFLICT_LOC_EN
  logic [3:0] conf_row, conf_col;
`endif

  always #5 clock = ~clock;

  sudoku_checker dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .grid(grid),
    .busy(busy),
    .done(done),
    .result_valid(result_valid),
    .conflict(conflict),
    .filled(filled),
    .solved(solved)
`ifdef CONFLICT_LOC_EN
    ,
    .conf_row(conf_row),
    .conf_col(conf_col)
`endif
  );

  typedef struct {
    int   t0;
    logic conflict;
    logic filled;
    logic solved;
    int   row;
    int   col;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clock) begin : mon
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc - e.t0, 244);
        chk("conflict", int'(conflict), int'(e.conflict));
        chk("filled", int'(filled), int'(e.filled));
        chk("solved", int'(solved), int'(e.solved));
        chk("result_valid", int'(result_valid), 1);
        chk("busy_at_done", int'(busy), 0);
`ifdef CONFLICT_LOC_EN
        chk("conf_row", int'(conf_row), e.row);
        chk("conf_col", int'(conf_col), e.col);
`endif
      end
    end
  end

  task automatic set_base();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        grid[r][c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
  endtask

  task automatic set_empty();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        grid[r][c] = 4'd0;
  endtask

  // Called at a negedge; raises start for one cycle and records the expectation.
  task automatic issue(input logic c, input logic f, input logic s, input int r, input int col);
    exp_t e;
    e.t0 = cyc; e.conflict = c; e.filled = f; e.solved = s; e.row = r; e.col = col;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("valid_cleared", int'(result_valid), 0);
  endtask

  task automatic wait_sb(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_%s: %0d results outstanding, expected 0", tag, sb.size());
      sb.delete();
    end
    // Step past the DONE cycle so the next start lands in IDLE.
    repeat (2) @(negedge clock);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_valid"}, int'(result_valid), 0);
    chk({tag, "_conflict"}, int'(conflict), 0);
    chk({tag, "_filled"}, int'(filled), 0);
    chk({tag, "_solved"}, int'(solved), 0);
`ifdef CONFLICT_LOC_EN
    chk({tag, "_conf_row"}, int'(conf_row), 0);
    chk({tag, "_conf_col"}, int'(conf_col), 0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_empty();
    repeat (3) @(negedge clock);
    chk_cleared("reset");
    // start together with reset must be dropped
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("reset_beats_start", int'(busy), 0);
    reset = 1'b0;
    @(negedge clock);

    // 1: solved board
    set_base();
    issue(1'b0, 1'b1, 1'b1, 0, 0);
    repeat (120) @(negedge clock);
    chk("busy_mid_scan", int'(busy), 1);
    wait_sb("solved");
    chk("hold_solved", int'(solved), 1);

    // 2: one empty cell
    set_base();
    grid[0][0] = 4'd0;
    issue(1'b0, 1'b0, 1'b0, 0, 0);
    wait_sb("empty_cell");

    // 3: row 4 holds two 1s, second at column 5
    set_base();
    grid[4][4] = 4'd1;
    issue(1'b1, 1'b1, 1'b0, 4, 5);
    wait_sb("row_dup");

    // 4: duplicate only inside box 8
    set_empty();
    grid[6][6] = 4'd1;
    grid[7][7] = 4'd1;
    issue(1'b1, 1'b0, 1'b0, 7, 7);
    wait_sb("box_dup");

    // 5: illegal value
    set_base();
    grid[8][8] = 4'd12;
    issue(1'b1, 1'b1, 1'b0, 8, 8);
    wait_sb("illegal");

    // empty board is legal but not filled
    set_empty();
    issue(1'b0, 1'b0, 1'b0, 0, 0);
    wait_sb("all_empty");

    // 6: grid change plus start mid-scan are ignored
    set_base();
    issue(1'b0, 1'b1, 1'b1, 0, 0);
    repeat (99) @(negedge clock);
    set_empty();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_sb("snapshot");

    // reset partway through a scan aborts it and clears outputs
    set_base();
    grid[8][8] = 4'd12;
    issue(1'b1, 1'b1, 1'b0, 8, 8);
    repeat (49) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    sb.delete();
    chk_cleared("mid_reset");
    reset = 1'b0;
    @(negedge clock);
    set_base();
    issue(1'b0, 1'b1, 1'b1, 0, 0);
    wait_sb("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
